instr_fetch_unit: RTL

- Initiator side of the instruction-memory read interface: drives ADDBUS/RD into ram_instruction and captures DATAOUT.
- Holds the program counter and a small prefetch FIFO of {pc, instruction} pairs.
- Presents instructions to the core decode stage with a valid/ready handshake.
- Supports single-cycle jump redirect, which flushes the FIFO and squashes the in-flight read.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction fetch unit.
//   FETCH_ADDR_W / FETCH_DATA_W : default address and instruction widths
//   fetch_state_e               : fetch FSM states
//   fetch_entry_t               : prefetch FIFO entry {pc, instr}
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used as the instruction prefetch buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO (wins over push/pop)
//   push, din  : write an entry
//   pop        : drop the head entry
//   head       : head entry, zero while empty
//   count      : current occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign head   = count != '0 ? mem[rptr] : '0;

    always_ff @(posedge clk)
        if (push && !flush) mem[wptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction-memory read initiator with PC, prefetch FIFO and jump redirect.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : fetching permitted while high
//   ADDBUS, RD            : registered read address / strobe to instruction RAM
//   DATAOUT               : RAM read data, valid the cycle after RAM samples RD
//   jump_en, jump_addr    : one-cycle redirect request and target
//   instr_out, instr_pc   : FIFO head instruction and its address
//   instr_valid/ready     : handshake with the decode stage
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W     = FETCH_ADDR_W,
    parameter int                 DATA_W     = FETCH_DATA_W,
    parameter int                 DEPTH      = 2,
    parameter int                 PC_STEP    = 1,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] ADDBUS,
    output logic              RD,
    input  logic [DATA_W-1:0] DATAOUT,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e              state;
    logic [ADDR_W-1:0]         pc, req_addr;
    logic                      inflight, squash, pop, push, issue;
    logic [CW-1:0]             count;
    logic [ADDR_W+DATA_W-1:0]  head;

    assign pop  = instr_valid && instr_ready && !jump_en;
    assign push = inflight && !squash && !jump_en;
    // Credit counts every read not yet landed in the FIFO: one just strobed (RD)
    // and one whose data is on DATAOUT now (inflight).
    assign issue = state == FETCH && !jump_en &&
                   (int'(count) + int'(inflight) + int'(RD) - int'(pop)) < DEPTH;

    assign instr_valid = count != '0;
    assign instr_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign instr_out   = head[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= START_ADDR;
            ADDBUS   <= START_ADDR;
            RD       <= 1'b0;
            inflight <= 1'b0;
            squash   <= 1'b0;
            req_addr <= '0;
        end else begin
            RD       <= issue;
            inflight <= RD;
            req_addr <= ADDBUS;
            if (issue) begin
                ADDBUS <= pc;
                pc     <= pc + ADDR_W'(PC_STEP);
            end
            if (jump_en) begin
                pc    <= jump_addr;
                state <= FLUSH;
                // A response landing on this edge is dropped by the flush itself;
                // only a read strobed right now still has data coming next cycle.
                squash <= RD;
            end else begin
                state <= enable ? FETCH : IDLE;
                if (inflight) squash <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .W    (ADDR_W + DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(jump_en),
        .push (push),
        .pop  (pop),
        .din  ({req_addr, DATAOUT}),
        .head (head),
        .count(count)
    );

endmodule
